// File: rtl/rf_post.sv
// Register file with one write port and one registered read port.
// Same-address read-during-write returns the incoming data; reset clears every entry.
module rf_post #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              W_E,
   input  logic [ADDR_W-1:0] W_A,
   input  logic [DATA_W-1:0] I,
   input  logic              R_E,
   input  logic [ADDR_W-1:0] R_A,
   output logic [DATA_W-1:0] Re_out
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rd_q;
   logic [DATA_W-1:0] rd_d;
   logic [IDX_W-1:0]  w_idx;
   logic [IDX_W-1:0]  r_idx;

   // Every address pattern folds onto a real entry; no out-of-range case exists.
   assign w_idx = IDX_W'(32'(W_A) % 32'(DEPTH));
   assign r_idx = IDX_W'(32'(R_A) % 32'(DEPTH));

   always_comb begin
      mem_d = mem_q;
      rd_d  = rd_q;
      if (W_E) begin
         mem_d[w_idx] = I;
      end
      if (R_E) begin
         rd_d = (W_E && (w_idx == r_idx)) ? I : mem_q[r_idx];
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         mem_q <= '{default: '0};
         rd_q  <= '0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
      end
   end

   assign Re_out = rd_q;

endmodule

// File: tb/tb_rf_post.sv
// Self-checking bench for rf_post: directed scenarios plus randomized traffic
// checked every cycle against an array model that applies writes before reads.
module tb_rf_post;

   localparam int DW = 8;
   localparam int AW = 5;
   localparam int N  = 32;

   logic          clk;
   logic          rst_n;
   logic          we;
   logic [AW-1:0] wa;
   logic [DW-1:0] din;
   logic          re;
   logic [AW-1:0] ra;
   logic [DW-1:0] re_out;

   int n_chk  = 0;
   int n_fail = 0;

   logic [DW-1:0] mdl [N];
   logic [DW-1:0] mdl_rd;
   bit            mdl_valid = 0;
   logic [DW-1:0] vals [N];

   rf_post #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(N)) dut (
      .CLK(clk), .RST_N(rst_n), .W_E(we), .W_A(wa), .I(din),
      .R_E(re), .R_A(ra), .Re_out(re_out)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Model: this cycle's write lands first, then a read sees the resulting array.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) mdl[k] = '0;
         mdl_rd    = '0;
         mdl_valid = 1;
      end else if (mdl_valid) begin
         if (we) mdl[int'(wa) % N] = din;
         if (re) mdl_rd = mdl[int'(ra) % N];
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mdl_valid) chk("model_cmp", re_out, mdl_rd);
   end

   task automatic step(input logic r, input logic w_e, input int w_a, input logic [DW-1:0] d,
                       input logic r_e, input int r_a);
      rst_n = r; we = w_e; wa = AW'(w_a); din = d; re = r_e; ra = AW'(r_a);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 0; we = 0; wa = '0; din = '0; re = 0; ra = '0;

      // Reset for two cycles with write/read requested: reset must win.
      step(0, 1, 4, 8'h3C, 1, 4);
      step(0, 1, 7, 8'h99, 1, 7);
      chk("reset_out", re_out, 8'h00);
      for (int a = 0; a < N; a++) begin
         step(1, 0, 0, 8'h00, 1, a);
         chk("reset_rd", re_out, 8'h00);
      end

      // Distinct fill values, addr 5 pinned to 0xA7.
      for (int a = 0; a < N; a++) begin
         bit dup;
         do begin
            vals[a] = (a == 5) ? 8'hA7 : DW'($urandom_range(255));
            dup = 0;
            for (int b = 0; b < a; b++) if (vals[b] == vals[a]) dup = 1;
            if (a != 5 && vals[a] == 8'hA7) dup = 1;
         end while (dup);
      end
      for (int a = 0; a < N; a++) step(1, 1, a, vals[a], 0, 0);
      chk("fill_hold", re_out, 8'h00);
      for (int a = 0; a < N; a++) begin
         step(1, 0, 0, 8'h00, 1, a);
         chk("fill_rd", re_out, vals[a]);
      end

      step(1, 0, 0, 8'h00, 1, 5);
      chk("rd_addr5", re_out, 8'hA7);
      step(1, 0, 0, 8'h00, 0, 6);
      chk("hold_addr6", re_out, 8'hA7);
      step(1, 0, 0, 8'h00, 0, 6);
      chk("hold_again", re_out, 8'hA7);

      step(1, 0, 3, 8'hFF, 0, 0);
      step(1, 0, 0, 8'h00, 1, 3);
      chk("wr_disable", re_out, vals[3]);

      // Read-during-write: different address returns old content.
      step(1, 1, 12, 8'h42, 1, 13);
      chk("rdw_diff", re_out, vals[13]);

      step(1, 1, 10, 8'h11, 0, 0);
      step(1, 1, 10, 8'h5C, 1, 10);
      chk("bypass", re_out, 8'h5C);
      step(1, 0, 0, 8'h00, 1, 10);
      chk("bypass_stored", re_out, 8'h5C);
      step(1, 0, 0, 8'h00, 1, 12);
      chk("rdw_diff_stored", re_out, 8'h42);

      // Mid-operation reset wipes everything.
      step(0, 1, 20, 8'hEE, 1, 5);
      chk("midrst_out", re_out, 8'h00);
      for (int a = 0; a < N; a++) begin
         step(1, 0, 0, 8'h00, 1, a);
         chk("midrst_rd", re_out, 8'h00);
      end

      // Randomized traffic, narrow address window some of the time to force collisions.
      for (int c = 0; c < 600; c++) begin
         int lim;
         lim = ($urandom_range(3) == 0) ? 3 : N - 1;
         step(($urandom_range(99) == 0) ? 1'b0 : 1'b1,
              1'($urandom_range(1)), $urandom_range(lim), DW'($urandom_range(255)),
              1'($urandom_range(1)), $urandom_range(lim));
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
